// File: rtl/x448_pkg.sv
// x448_pkg: shared constants for the curve448 arithmetic blocks.
// Holds the field prime, its reduction constant, the default operand
// width and the responder state encoding seen by the point sequencers.
package x448_pkg;

    // Default operand/modulus width and iteration count.
    localparam int DEFAULT_N = 448;

    // P448 = 2^448 - 2^224 - 1 (bit 224 is the only clear bit).
    localparam logic [447:0] P448 = {{223{1'b1}}, 1'b0, {224{1'b1}}};

    // K448 = 2^448 mod P448 = 2^224 + 1.
    localparam logic [447:0] K448 = {{223{1'b0}}, 1'b1, {223{1'b0}}, 1'b1};

    // Responder handshake states. The sequencers decode the same values.
    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_ACK  = 2'd1;
    localparam logic [1:0] STATE_RUN  = 2'd2;
    localparam logic [1:0] STATE_POST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_ACK  = STATE_ACK,
        ST_RUN  = STATE_RUN,
        ST_POST = STATE_POST
    } mulmod_state_t;

endpackage

// File: rtl/mulmod_serial_if.sv
// mulmod_serial_if: req/res handshake bundle between a point sequencer
// (master) and the serial modular multiplier (slave).
interface mulmod_serial_if
    import x448_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic [N-1:0] M;
    logic [N-1:0] Z;
    logic         req_valid;
    logic         req_ready;
    logic         req_busy;
    logic         res_valid;
    logic         res_ready;

    modport master (
        output X, Y, M, req_valid, res_ready,
        input  Z, req_ready, req_busy, res_valid
    );

    modport slave (
        input  X, Y, M, req_valid, res_ready,
        output Z, req_ready, req_busy, res_valid
    );
endinterface

// File: rtl/mulmod_step.sv
// mulmod_step: one interleaved shift-add-reduce iteration,
// acc' = (2*acc + (bit ? x : 0)) mod m, assuming acc, x < m.
// Purely combinational so a wider-radix variant can chain several.
module mulmod_step
    import x448_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0] i_acc,
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_m,
    input  logic         i_bit,
    output logic [N-1:0] o_acc
);
    logic [N+1:0] w_t;
    logic [N+1:0] w_t1;
    logic [N+1:0] w_m;

    // Double, conditionally add, then subtract m up to twice (t < 3m).
    // The second subtraction lands below m < 2^N, so it is done in N bits.
    always_comb begin
        w_m  = {2'b00, i_m};
        w_t  = {1'b0, i_acc, 1'b0} + (i_bit ? {2'b00, i_x} : '0);
        w_t1 = (w_t >= w_m) ? (w_t - w_m) : w_t;
        o_acc = w_t1[N-1:0] - ((w_t1 >= w_m) ? i_m : '0);
    end
endmodule

// File: rtl/mulmod_serial.sv
// mulmod_serial: bit-serial Z = X*Y mod M responder, one iteration per
// clock, MSB of Y first. Optional macro MULMOD_SKIP_LZ_EN starts at the
// highest set bit of Y (data-dependent latency; non-secret data only).
module mulmod_serial
    import x448_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst,
    mulmod_serial_if.slave bus
);
    localparam int CW = $clog2(N);

    mulmod_state_t r_state;
    mulmod_state_t w_nextState;

    logic [N-1:0]  r_xr;
    logic [N-1:0]  r_yr;
    logic [N-1:0]  r_mr;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_z;
    logic [N-1:0]  w_stepAcc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntLoad;
    logic          r_reqReady;
    logic          r_reqBusy;
    logic          r_resValid;
    logic          w_lastIter;

    mulmod_step #(.N(N)) u_step (
        .i_acc (r_acc),
        .i_x   (r_xr),
        .i_m   (r_mr),
        .i_bit (r_yr[r_cnt]),
        .o_acc (w_stepAcc)
    );

`ifdef MULMOD_SKIP_LZ_EN
    // Priority encoder: start at the highest set bit of Y. Y=0 loads 0,
    // so the single ACK iteration sees bit 0 = 0 and posts Z=0.
    always_comb begin
        w_cntLoad = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.Y[i]) begin
                w_cntLoad = CW'(i);
            end
        end
    end
`else
    assign w_cntLoad = CW'(N - 1);
`endif

    assign w_lastIter = (r_cnt == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; req_valid only matters in IDLE, res_ready only in POST.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (bus.req_valid) w_nextState = ST_ACK;
            ST_ACK,
            ST_RUN:  w_nextState = w_lastIter ? ST_POST : ST_RUN;
            ST_POST: if (bus.res_ready) w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xr       <= '0;
            r_yr       <= '0;
            r_mr       <= '0;
            r_acc      <= '0;
            r_z        <= '0;
            r_cnt      <= '0;
            r_reqReady <= 1'b0;
            r_reqBusy  <= 1'b0;
            r_resValid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_xr       <= bus.X;
                        r_yr       <= bus.Y;
                        r_mr       <= bus.M;
                        r_acc      <= '0;
                        r_cnt      <= w_cntLoad;
                        r_reqReady <= 1'b1;
                        r_reqBusy  <= 1'b1;
                    end
                end
                ST_ACK,
                ST_RUN: begin
                    r_reqReady <= 1'b0;
                    r_acc      <= w_stepAcc;
                    if (w_lastIter) begin
                        r_z        <= w_stepAcc;
                        r_resValid <= 1'b1;
                        r_reqBusy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_POST: begin
                    if (bus.res_ready) begin
                        r_resValid <= 1'b0;
                    end
                end
                default: begin
                    r_reqReady <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Z         = r_z;
    assign bus.req_ready = r_reqReady;
    assign bus.req_busy  = r_reqBusy;
    assign bus.res_valid = r_resValid;
endmodule

// File: tb/tb_mulmod_serial.sv
// tb_mulmod_serial: scoreboard bench for mulmod_serial. Expected results
// and latencies are queued when a request is driven and compared when
// res_valid appears. Latency expectation follows MULMOD_SKIP_LZ_EN.
module tb_mulmod_serial;
    import x448_pkg::*;

    localparam int N = DEFAULT_N;

    typedef struct {
        logic [N-1:0] z;
        int           lat;
    } expect_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;
    expect_t sb[$];

    mulmod_serial_if #(.N(N)) bus ();

    mulmod_serial #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference product, independent of the serial algorithm.
    function automatic logic [N-1:0] refMulMod(input logic [N-1:0] x, input logic [N-1:0] y,
                                               input logic [N-1:0] m);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        p = p % {{N{1'b0}}, m};
        return p[N-1:0];
    endfunction

    // Edges from accept to res_valid for a given multiplier.
    function automatic int expLatency(input logic [N-1:0] y);
`ifdef MULMOD_SKIP_LZ_EN
        int msb = 0;
        for (int i = 0; i < N; i++) begin
            if (y[i]) msb = i;
        end
        return msb + 1;
`else
        return N;
`endif
    endfunction

    // Drive one request, queue its expectation, confirm the accept edge.
    task automatic applyStimulus(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic [N-1:0] m, input logic [N-1:0] z);
        expect_t e;
        e.z   = z;
        e.lat = expLatency(y);
        sb.push_back(e);
        @(negedge clk);
        bus.X         = x;
        bus.Y         = y;
        bus.M         = m;
        bus.req_valid = 1'b1;
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_accept_ready"}, N'(bus.req_ready), N'(1));
        checkOutput({tag, "_accept_busy"}, N'(bus.req_busy), N'(1));
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.X         = '1;
        bus.Y         = '1;
        bus.M         = '1;
    endtask

    // Wait (bounded) for the result, compare against the scoreboard,
    // optionally stall res_ready, then release the result.
    task automatic awaitResult(input string tag, input int holdCycles, input logic keepReady);
        expect_t      e;
        int           lat;
        logic         busyOk;
        logic         pulseOk;
        logic         stable;
        logic [N-1:0] zSeen;
        lat     = 0;
        busyOk  = 1'b1;
        pulseOk = 1'b1;
        stable  = 1'b1;
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, N'(0), N'(1));
            return;
        end
        e = sb.pop_front();
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.req_ready) pulseOk = 1'b0;
            if (!bus.res_valid && !bus.req_busy) busyOk = 1'b0;
        end while (!bus.res_valid && lat <= N + 8);
        checkOutput({tag, "_valid"}, N'(bus.res_valid), N'(1));
        checkOutput({tag, "_latency"}, N'(lat), N'(e.lat));
        checkOutput({tag, "_ready_pulse"}, N'(pulseOk), N'(1));
        checkOutput({tag, "_busy_held"}, N'(busyOk), N'(1));
        checkOutput({tag, "_busy_low"}, N'(bus.req_busy), N'(0));
        checkOutput({tag, "_z"}, bus.Z, e.z);
        zSeen = bus.Z;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            if (!bus.res_valid || bus.Z !== zSeen) stable = 1'b0;
        end
        if (holdCycles > 0) checkOutput({tag, "_hold"}, N'(stable), N'(1));
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_drop"}, N'(bus.res_valid), N'(0));
        if (!keepReady) begin
            @(negedge clk);
            bus.res_ready = 1'b0;
        end
    endtask

    // Hard stop if anything wedges beyond all bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        logic [N-1:0] big;
        logic [N-1:0] expBig;
        logic [N-1:0] rx;
        logic [N-1:0] ry;
        logic         sawValid;

        bus.X         = '0;
        bus.Y         = '0;
        bus.M         = '0;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        rst           = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_z", bus.Z, '0);
        checkOutput("reset_res_valid", N'(bus.res_valid), N'(0));
        checkOutput("reset_req_ready", N'(bus.req_ready), N'(0));
        checkOutput("reset_req_busy", N'(bus.req_busy), N'(0));
        @(negedge clk);
        rst = 1'b1;

        // 3*5 with a 10-cycle stall, res_ready left high into the next request.
        applyStimulus("small", N'(3), N'(5), P448, N'(15));
        awaitResult("small", 10, 1'b1);

        // (P-1)^2 = 1 mod P, issued sequencer-style right after the drop.
        applyStimulus("pm1", P448 - N'(1), P448 - N'(1), P448, N'(1));
        awaitResult("pm1", 0, 1'b0);

        // 2^447 * 2 = 2^448 = 2^224 + 1 mod P.
        big         = '0;
        big[447]    = 1'b1;
        expBig      = '0;
        expBig[224] = 1'b1;
        expBig[0]   = 1'b1;
        applyStimulus("wrap", big, N'(2), P448, expBig);
        awaitResult("wrap", 0, 1'b0);

        // Random operands reduced below P, checked against the wide model.
        for (int t = 0; t < 3; t++) begin
            rx = '0;
            ry = '0;
            for (int k = 0; k < 14; k++) begin
                rx = {rx[N-33:0], $urandom()};
                ry = {ry[N-33:0], $urandom()};
            end
            rx = rx % P448;
            ry = ry % P448;
            applyStimulus("rand", rx, ry, P448, refMulMod(rx, ry, P448));
            awaitResult("rand", 0, 1'b0);
        end

        // Asynchronous reset around iteration 200 aborts the operation.
        applyStimulus("abort", N'(11), P448 - N'(5), P448, '0);
        repeat (199) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("abort_z", bus.Z, '0);
        checkOutput("abort_res_valid", N'(bus.res_valid), N'(0));
        checkOutput("abort_req_ready", N'(bus.req_ready), N'(0));
        checkOutput("abort_req_busy", N'(bus.req_busy), N'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < N + 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) sawValid = 1'b1;
        end
        checkOutput("abort_no_valid", N'(sawValid), N'(0));

        // Normal operation after the aborted one.
        applyStimulus("after_reset", N'(7), N'(9), P448, N'(63));
        awaitResult("after_reset", 0, 1'b0);

        // Y=0 and Y=1 corner cases; latency depends on the skip macro.
        applyStimulus("y_zero", N'(12345), N'(0), P448, N'(0));
        awaitResult("y_zero", 0, 1'b0);
        applyStimulus("y_one", N'(12345), N'(1), P448, N'(12345));
        awaitResult("y_one", 0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
